// File: rtl/truth_table_sweeper.sv
// truth_table_sweeper
// Drives a 3-input combinational circuit through rows 0..7 ({in1,in2,in3}),
// holds each row for SETTLE_CYCLES cycles, takes SAMPLES majority-voted
// samples of the circuit output, and assembles the observed truth table
// (row 0 in obs_tt[7], row 7 in obs_tt[0]). At the end of the sweep the
// observed table is compared with the expected table latched at start.
//
// Optional feature macro: TT_SWEEP_MISMATCH_LOG_EN
//   Adds mismatch_mask (obs_tt ^ exp_tt, built row by row) and the sticky
//   first_fail_row / first_fail_vld capture of the lowest failing row.
//
// Parameter ranges: SETTLE_CYCLES 1..15, SAMPLES odd 1..7.

module truth_table_sweeper #(
    parameter int unsigned SETTLE_CYCLES = 4,
    parameter int unsigned SAMPLES       = 3
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic [7:0] exp_tt,
    input  logic       dut_out,
    output logic       in1,
    output logic       in2,
    output logic       in3,
    output logic       busy,
    output logic       done,
    output logic       pass,
    output logic [7:0] obs_tt
`ifdef TT_SWEEP_MISMATCH_LOG_EN
    ,
    output logic [7:0] mismatch_mask,
    output logic [2:0] first_fail_row,
    output logic       first_fail_vld
`endif
);

    // Counter reload values and the vote threshold, all fixed at elaboration.
    localparam logic [3:0] SETTLE_LOAD = 4'(SETTLE_CYCLES - 1);
    localparam logic [2:0] SAMPLE_LAST = 3'(SAMPLES - 1);
    localparam logic [2:0] VOTE_THRESH = 3'(SAMPLES / 2);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETTLE = 2'd1,
        ST_SAMPLE = 2'd2,
        ST_DONE   = 2'd3
    } state_t;

    // Row r is stored in truth-table bit 7-r so the hex label reads row 0 first.
    function automatic logic [2:0] tt_bit_index(input logic [2:0] row);
        return 3'd7 - row;
    endfunction

    // Strict majority over SAMPLES samples: more ones than half the samples.
    function automatic logic majority_vote(input logic [2:0] ones);
        return (ones > VOTE_THRESH);
    endfunction

    state_t     state_r;
    logic [2:0] row_r;
    logic [3:0] settle_cnt_r;
    logic [2:0] sample_cnt_r;
    logic [2:0] ones_r;
    logic [7:0] exp_tt_r;
    logic       busy_r;
    logic       done_r;
    logic       pass_r;
    logic [7:0] obs_tt_r;

    logic       start_accept_s;
    logic       row_complete_s;
    logic [2:0] ones_total_s;
    logic       vote_s;
    logic [2:0] bit_idx_s;
    logic [7:0] obs_next_s;

    // Decode sweep events and build the next observed table for the current row.
    always_comb begin
        start_accept_s = 1'b0;
        row_complete_s = 1'b0;
        ones_total_s   = ones_r + {2'b00, dut_out};
        vote_s         = majority_vote(ones_total_s);
        bit_idx_s      = tt_bit_index(row_r);
        obs_next_s     = obs_tt_r;
        if (state_r == ST_IDLE) begin
            start_accept_s = start;
        end else begin
            start_accept_s = 1'b0;
        end
        if ((state_r == ST_SAMPLE) && (sample_cnt_r == SAMPLE_LAST)) begin
            row_complete_s = 1'b1;
        end else begin
            row_complete_s = 1'b0;
        end
        obs_next_s[bit_idx_s] = vote_s;
    end

    // Sweep FSM with all outputs registered; rst aborts any sweep at once.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r      <= ST_IDLE;
            row_r        <= 3'd0;
            settle_cnt_r <= 4'd0;
            sample_cnt_r <= 3'd0;
            ones_r       <= 3'd0;
            exp_tt_r     <= 8'h00;
            busy_r       <= 1'b0;
            done_r       <= 1'b0;
            pass_r       <= 1'b0;
            obs_tt_r     <= 8'h00;
        end else begin
            done_r <= 1'b0;
            case (state_r)
                ST_IDLE: begin
                    if (start) begin
                        exp_tt_r     <= exp_tt;
                        obs_tt_r     <= 8'h00;
                        pass_r       <= 1'b0;
                        row_r        <= 3'd0;
                        settle_cnt_r <= SETTLE_LOAD;
                        sample_cnt_r <= 3'd0;
                        ones_r       <= 3'd0;
                        busy_r       <= 1'b1;
                        state_r      <= ST_SETTLE;
                    end else begin
                        state_r <= ST_IDLE;
                    end
                end
                ST_SETTLE: begin
                    if (settle_cnt_r == 4'd0) begin
                        sample_cnt_r <= 3'd0;
                        ones_r       <= 3'd0;
                        state_r      <= ST_SAMPLE;
                    end else begin
                        settle_cnt_r <= settle_cnt_r - 4'd1;
                    end
                end
                ST_SAMPLE: begin
                    if (sample_cnt_r == SAMPLE_LAST) begin
                        obs_tt_r     <= obs_next_s;
                        sample_cnt_r <= 3'd0;
                        ones_r       <= 3'd0;
                        if (row_r == 3'd7) begin
                            // Inputs fall back to row 0 and busy drops before the done cycle.
                            row_r   <= 3'd0;
                            busy_r  <= 1'b0;
                            state_r <= ST_DONE;
                        end else begin
                            row_r        <= row_r + 3'd1;
                            settle_cnt_r <= SETTLE_LOAD;
                            state_r      <= ST_SETTLE;
                        end
                    end else begin
                        sample_cnt_r <= sample_cnt_r + 3'd1;
                        ones_r       <= ones_total_s;
                    end
                end
                ST_DONE: begin
                    // start is deliberately ignored here; it is honoured next cycle in IDLE.
                    done_r  <= 1'b1;
                    pass_r  <= (obs_tt_r == exp_tt_r);
                    state_r <= ST_IDLE;
                end
                default: begin
                    state_r <= ST_IDLE;
                    row_r   <= 3'd0;
                    busy_r  <= 1'b0;
                    pass_r  <= 1'b0;
                end
            endcase
        end
    end

    assign in1    = row_r[2];
    assign in2    = row_r[1];
    assign in3    = row_r[0];
    assign busy   = busy_r;
    assign done   = done_r;
    assign pass   = pass_r;
    assign obs_tt = obs_tt_r;

`ifdef TT_SWEEP_MISMATCH_LOG_EN
    logic [7:0] mismatch_mask_r;
    logic [2:0] first_fail_row_r;
    logic       first_fail_vld_r;
    logic       row_mismatch_s;

    // A completed row mismatches when its voted value differs from the latched expectation.
    always_comb begin
        row_mismatch_s = 1'b0;
        if (row_complete_s) begin
            row_mismatch_s = vote_s ^ exp_tt_r[bit_idx_s];
        end else begin
            row_mismatch_s = 1'b0;
        end
    end

    // Build the mismatch mask row by row and keep the lowest failing row (rows complete in ascending order).
    always_ff @(posedge clk) begin
        if (rst) begin
            mismatch_mask_r  <= 8'h00;
            first_fail_row_r <= 3'd0;
            first_fail_vld_r <= 1'b0;
        end else if (start_accept_s) begin
            mismatch_mask_r  <= 8'h00;
            first_fail_row_r <= 3'd0;
            first_fail_vld_r <= 1'b0;
        end else if (row_complete_s) begin
            mismatch_mask_r[bit_idx_s] <= row_mismatch_s;
            if (row_mismatch_s && !first_fail_vld_r) begin
                first_fail_row_r <= row_r;
                first_fail_vld_r <= 1'b1;
            end else begin
                first_fail_vld_r <= first_fail_vld_r;
            end
        end else begin
            mismatch_mask_r <= mismatch_mask_r;
        end
    end

    assign mismatch_mask  = mismatch_mask_r;
    assign first_fail_row = first_fail_row_r;
    assign first_fail_vld = first_fail_vld_r;
`endif

endmodule

// File: tb/tb_truth_table_sweeper.sv
// Self-checking bench for truth_table_sweeper.
// Instance A uses the default parameters (settle 4, samples 3); instance B
// uses a single sample per row so that a one-cycle glitch is not filtered.
// Both share clk/rst/start/exp_tt; each sees its own behavioural circuit.

module tb_truth_table_sweeper;

    logic       clk = 1'b0;
    logic       rst;
    logic       start;
    logic [7:0] exp_tt;

    logic       in1_a, in2_a, in3_a, busy_a, done_a, pass_a, dut_out_a;
    logic [7:0] obs_a;
    logic       in1_b, in2_b, in3_b, busy_b, done_b, pass_b, dut_out_b;
    logic [7:0] obs_b;
`ifdef TT_SWEEP_MISMATCH_LOG_EN
    logic [7:0] mm_a, mm_b;
    logic [2:0] ffr_a, ffr_b;
    logic       ffv_a, ffv_b;
`endif

    int         ecnt = 0;          // before an edge: the index of that edge
    logic [7:0] circ_a, circ_b;    // truth tables of the behavioural circuits
    int         glitch_a, glitch_b;
    logic [2:0] row_a, row_b;

    int checks   = 0;
    int failures = 0;

    int         s0, done_edge_a, done_edge_b, busy_cnt_a, done_cnt_a;
    logic [7:0] obs_done_a, obs_done_b, et_latched;
    logic       pass_done_a, pass_done_b;
`ifdef TT_SWEEP_MISMATCH_LOG_EN
    logic [7:0] mm_done_a;
    logic [2:0] ffr_done_a;
    logic       ffv_done_a;
`endif

    always #5 clk = ~clk;

    always @(posedge clk) ecnt <= ecnt + 1;

    assign row_a     = {in1_a, in2_a, in3_a};
    assign row_b     = {in1_b, in2_b, in3_b};
    assign dut_out_a = circ_a[3'd7 - row_a] ^ (ecnt == glitch_a);
    assign dut_out_b = circ_b[3'd7 - row_b] ^ (ecnt == glitch_b);

    truth_table_sweeper #(.SETTLE_CYCLES(4), .SAMPLES(3)) u_dut_a (
        .clk(clk), .rst(rst), .start(start), .exp_tt(exp_tt), .dut_out(dut_out_a),
        .in1(in1_a), .in2(in2_a), .in3(in3_a), .busy(busy_a), .done(done_a),
        .pass(pass_a), .obs_tt(obs_a)
`ifdef TT_SWEEP_MISMATCH_LOG_EN
        , .mismatch_mask(mm_a), .first_fail_row(ffr_a), .first_fail_vld(ffv_a)
`endif
    );

    truth_table_sweeper #(.SETTLE_CYCLES(4), .SAMPLES(1)) u_dut_b (
        .clk(clk), .rst(rst), .start(start), .exp_tt(exp_tt), .dut_out(dut_out_b),
        .in1(in1_b), .in2(in2_b), .in3(in3_b), .busy(busy_b), .done(done_b),
        .pass(pass_b), .obs_tt(obs_b)
`ifdef TT_SWEEP_MISMATCH_LOG_EN
        , .mismatch_mask(mm_b), .first_fail_row(ffr_b), .first_fail_vld(ffv_b)
`endif
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, expv);
        end
    endtask

    // Reference: row r is held from s0+r*(settle+samples)+1 and sampled on the
    // last `samples` edges of its slot; each sample is the circuit value,
    // inverted if it falls on the glitch edge; the row is 1 on strict majority.
    function automatic logic [7:0] model_tt(input logic [7:0] circ, input int start_edge,
                                            input int settle, input int samples, input int g);
        logic [7:0] res;
        res = 8'h00;
        for (int r = 0; r < 8; r++) begin
            int ones;
            ones = 0;
            for (int j = 0; j < samples; j++) begin
                int e;
                e = start_edge + r * (settle + samples) + settle + 1 + j;
                ones += int'(circ[7 - r] ^ (e == g));
            end
            res[7 - r] = (ones * 2 > samples);
        end
        return res;
    endfunction

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1; start = 1'b0; glitch_a = -1; glitch_b = -1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
    endtask

    // One sweep: pulse start, optionally re-pulse start (exp_tt=FF) at a given offset,
    // and watch both instances for a bounded window.
    task automatic sweep(input logic [7:0] ca, input logic [7:0] cb, input logic [7:0] et,
                         input int ga, input int gb, input int repulse_off);
        circ_a = ca; circ_b = cb; exp_tt = et; et_latched = et;
        @(negedge clk);
        s0 = ecnt;
        glitch_a = (ga < 0) ? -1 : s0 + ga;
        glitch_b = (gb < 0) ? -1 : s0 + gb;
        start = 1'b1;
        done_edge_a = -1; done_edge_b = -1; busy_cnt_a = 0; done_cnt_a = 0;
        for (int i = 0; i < 80; i++) begin
            @(negedge clk);
            start = (repulse_off >= 0) && (ecnt == s0 + repulse_off);
            if (start) exp_tt = 8'hFF;
            if (busy_a) busy_cnt_a++;
            if (done_a) begin
                done_cnt_a++;
                if (done_edge_a < 0) begin
                    done_edge_a = ecnt - 1;
                    obs_done_a = obs_a; pass_done_a = pass_a;
`ifdef TT_SWEEP_MISMATCH_LOG_EN
                    mm_done_a = mm_a; ffr_done_a = ffr_a; ffv_done_a = ffv_a;
`endif
                end
            end
            if (done_b && done_edge_b < 0) begin
                done_edge_b = ecnt - 1;
                obs_done_b = obs_b; pass_done_b = pass_b;
            end
        end
        start = 1'b0;
    endtask

    task automatic check_sweep(input string tag);
        logic [7:0] ea, eb;
        ea = model_tt(circ_a, s0, 4, 3, glitch_a);
        eb = model_tt(circ_b, s0, 4, 1, glitch_b);
        chk({tag, ".done_edge_a"}, done_edge_a, s0 + 57);
        chk({tag, ".done_cnt_a"}, done_cnt_a, 1);
        chk({tag, ".busy_cnt_a"}, busy_cnt_a, 56);
        chk({tag, ".obs_a"}, obs_done_a, ea);
        chk({tag, ".pass_a"}, pass_done_a, (ea == et_latched));
        chk({tag, ".done_edge_b"}, done_edge_b, s0 + 41);
        chk({tag, ".obs_b"}, obs_done_b, eb);
        chk({tag, ".pass_b"}, pass_done_b, (eb == et_latched));
`ifdef TT_SWEEP_MISMATCH_LOG_EN
        begin
            logic [7:0] mm;
            int         ff;
            mm = ea ^ et_latched;
            ff = -1;
            for (int r = 7; r >= 0; r--) if (mm[7 - r]) ff = r;
            chk({tag, ".mask_a"}, mm_done_a, mm);
            chk({tag, ".ffv_a"}, ffv_done_a, (ff >= 0));
            chk({tag, ".ffr_a"}, ffr_done_a, (ff >= 0) ? ff : 0);
        end
`endif
    endtask

    initial begin
        int first_done, second_done, rst_done_cnt;
        rst = 1'b1; start = 1'b0; exp_tt = 8'h00;
        circ_a = 8'h86; circ_b = 8'h86; glitch_a = -1; glitch_b = -1;
        et_latched = 8'h00;

        // Reset state
        do_reset();
        @(negedge clk);
        chk("reset.outs_a", {busy_a, done_a, pass_a, in1_a, in2_a, in3_a}, 6'b0);
        chk("reset.obs_a", obs_a, 8'h00);
`ifdef TT_SWEEP_MISMATCH_LOG_EN
        chk("reset.log_a", {mm_a, ffr_a, ffv_a}, 12'h000);
`endif

        // 1. Correct 0x86 circuit
        sweep(8'h86, 8'h86, 8'h86, -1, -1, -1);
        check_sweep("t1");
        chk("t1.obs_const", obs_done_a, 8'h86);
        chk("t1.pass_const", pass_done_a, 1'b1);

        // 2. Stuck-at-0 circuit
        sweep(8'h00, 8'h00, 8'h86, -1, -1, -1);
        check_sweep("t2");
        chk("t2.obs_const", obs_done_a, 8'h00);
`ifdef TT_SWEEP_MISMATCH_LOG_EN
        chk("t2.mask_const", mm_done_a, 8'h86);
        chk("t2.ffr_const", {ffv_done_a, ffr_done_a}, 4'b1000);
`endif

        // 3. One-cycle glitch on a row-5 sample: filtered by 3-vote, not by 1 sample
        sweep(8'h86, 8'h86, 8'h86, 41, 30, -1);
        check_sweep("t3");
        chk("t3.obs_a_const", obs_done_a, 8'h86);
        chk("t3.obs_b_const", obs_done_b, 8'h82);
        chk("t3.pass_b_const", pass_done_b, 1'b0);

        // 4. start re-pulsed while busy with exp_tt=FF is ignored
        sweep(8'h86, 8'h86, 8'h86, -1, -1, 20);
        check_sweep("t4");
        chk("t4.pass_const", pass_done_a, 1'b1);

        // 5. Reset mid-sweep, then a fresh sweep
        do_reset();
        circ_a = 8'h86; circ_b = 8'h86; exp_tt = 8'h86;
        @(negedge clk);
        s0 = ecnt; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        while (ecnt < s0 + 30) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        chk("t5.rst_outs_a", {busy_a, done_a, pass_a, in1_a, in2_a, in3_a}, 6'b0);
        chk("t5.rst_obs_a", obs_a, 8'h00);
`ifdef TT_SWEEP_MISMATCH_LOG_EN
        chk("t5.rst_log_a", {mm_a, ffr_a, ffv_a}, 12'h000);
`endif
        rst = 1'b0;
        rst_done_cnt = 0;
        for (int i = 0; i < 70; i++) begin
            @(negedge clk);
            if (done_a || done_b) rst_done_cnt++;
        end
        chk("t5.no_done", rst_done_cnt, 0);
        sweep(8'h86, 8'h86, 8'h86, -1, -1, -1);
        check_sweep("t5b");

        // 6. start held high: back-to-back sweeps
        do_reset();
        circ_a = 8'h86; circ_b = 8'h86; exp_tt = 8'h86;
        @(negedge clk);
        s0 = ecnt; start = 1'b1;
        first_done = -1; second_done = -1;
        for (int i = 0; i < 150; i++) begin
            @(negedge clk);
            if (done_a) begin
                if (first_done < 0) first_done = ecnt - 1;
                else if (second_done < 0) second_done = ecnt - 1;
            end
            if (first_done >= 0 && ecnt == first_done + 2) begin
                chk("t6.reaccept_pass", pass_a, 1'b0);
                chk("t6.reaccept_obs", obs_a, 8'h00);
                chk("t6.reaccept_busy", busy_a, 1'b1);
            end
        end
        start = 1'b0;
        chk("t6.first_done", first_done, s0 + 57);
        chk("t6.second_gap", second_done - first_done, 58);
        do_reset();

        // Randomized sweeps against the reference model
        for (int k = 0; k < 6; k++) begin
            logic [7:0] ca, et;
            ca = 8'($urandom_range(0, 255));
            et = ($urandom_range(0, 1) == 1) ? ca : 8'($urandom_range(0, 255));
            sweep(ca, ca, et, int'($urandom_range(1, 56)), int'($urandom_range(1, 40)), -1);
            check_sweep($sformatf("rnd%0d", k));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
